// File: rtl/cpu_fetch_pkg.sv
// Shared types and default constants for the instruction-fetch front end.
package cpu_fetch_pkg;

    localparam int unsigned       DEF_ADDR_WIDTH     = 32;
    localparam int unsigned       DEF_INSTR_WIDTH    = 32;
    localparam logic [31:0]       DEF_BOOT_ADDR      = 32'h0000_1000;
    localparam logic [31:0]       DEF_EXCEPTION_ADDR = 32'h0000_2000;
    // Byte distance between consecutive instruction words.
    localparam int unsigned       PC_STEP            = 4;

    // FETCH issues requests; HALTED waits for a redirect after a faulting fetch.
    typedef enum logic {
        FETCH,
        HALTED
    } fetch_state_t;

    // One prefetch-queue entry at the default widths.
    typedef struct packed {
        logic [DEF_INSTR_WIDTH-1:0] instr;
        logic [DEF_ADDR_WIDTH-1:0]  pc;
        logic                       fault;
    } fetch_entry_t;

endpackage

// File: rtl/cpu_fetch_fifo.sv
// Synchronous prefetch queue: DEPTH entries of a packed entry type, registered
// head with no fall-through, single-cycle flush. DEPTH must be a power of two
// so the pointers wrap naturally.
module cpu_fetch_fifo
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned DEPTH   = 4,
    parameter type         entry_t = fetch_entry_t
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       push_i,
    input  entry_t                     push_data_i,
    input  logic                       pop_i,
    input  logic                       flush_i,
    output entry_t                     head_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o,
    output logic                       full_o,
    output logic                       empty_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    entry_t             mem_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               do_push;
    logic               do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

    // A pop from an empty queue is ignored; a push into a full queue is only
    // accepted when the head leaves in the same cycle.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    // Head is forced to zero while empty so stale storage never shows on the outputs.
    assign head_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers and occupancy; flush wins over push/pop.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clock or negedge reset) begin
        // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
        if (!reset) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage write port.
    // NOTE: storage is deliberately not reset; occupancy gates every read, so its contents never matter when empty.
    always_ff @(posedge clock) begin
        if (do_push && !flush_i) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/cpu_fetch_prefetch.sv
// Instruction-fetch front end: owns the PC, issues in-order word requests to
// the icache with up to MAX_OUTSTANDING in flight, buffers returned words in a
// prefetch queue, and squashes in-flight responses after a redirect.
module cpu_fetch_prefetch
    import cpu_fetch_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int unsigned           INSTR_WIDTH     = DEF_INSTR_WIDTH,
    parameter int unsigned           DEPTH           = 4,
    parameter int unsigned           MAX_OUTSTANDING = 2,
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR       = ADDR_WIDTH'(DEF_BOOT_ADDR),
    parameter logic [ADDR_WIDTH-1:0] EXCEPTION_ADDR  = ADDR_WIDTH'(DEF_EXCEPTION_ADDR)
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   redirect_exception,
    input  logic                   redirect_jump,
    input  logic [ADDR_WIDTH-1:0]  jump_pc,
    output logic                   ic_req_valid,
    input  logic                   ic_req_ready,
    output logic [ADDR_WIDTH-1:0]  ic_req_addr,
    input  logic                   ic_rsp_valid,
    input  logic [INSTR_WIDTH-1:0] ic_rsp_data,
    input  logic                   ic_rsp_fault,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic [INSTR_WIDTH-1:0] instr,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_fault
);

    localparam int unsigned           CNT_W      = $clog2(DEPTH + 1);
    localparam int unsigned           SUM_W      = CNT_W + 1;
    localparam logic [ADDR_WIDTH-1:0] PC_INC     = ADDR_WIDTH'(PC_STEP);
    localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(3);

    typedef struct packed {
        logic [INSTR_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0]  pc;
        logic                   fault;
    } entry_t;

    fetch_state_t           state_q;
    logic [ADDR_WIDTH-1:0]  req_pc_q, req_pc_d;
    logic [ADDR_WIDTH-1:0]  rsp_pc_q, rsp_pc_d;
    logic [CNT_W-1:0]       outstanding_q, outstanding_d;
    logic [CNT_W-1:0]       drop_cnt_q, drop_cnt_d;

    logic                   redirect;
    logic [ADDR_WIDTH-1:0]  redirect_target;
    logic [SUM_W-1:0]       credit_sum;
    logic                   req_fire;
    logic                   rsp_drop;
    logic                   enqueue;
    logic                   dequeue;
    entry_t                 enq_entry;
    entry_t                 head;
    logic [CNT_W-1:0]       fifo_count;
    logic                   fifo_full;
    logic                   fifo_empty;

    // Exception beats jump; targets are always word aligned.
    assign redirect        = redirect_exception || redirect_jump;
    assign redirect_target = (redirect_exception ? EXCEPTION_ADDR : jump_pc) & ALIGN_MASK;

    // Queued plus in-flight words must fit in the queue, so responses never
    // need back-pressure. The full flag is a direct guard on the queue itself.
    // The request is also held off while reset is asserted.
    assign credit_sum   = SUM_W'(fifo_count) + SUM_W'(outstanding_q);
    assign ic_req_valid = reset
                          && (state_q == FETCH)
                          && !fifo_full
                          && (credit_sum < SUM_W'(DEPTH))
                          && (outstanding_q < CNT_W'(MAX_OUTSTANDING))
                          && !redirect;
    assign ic_req_addr  = req_pc_q;
    assign req_fire     = ic_req_valid && ic_req_ready;

    // Responses belonging to squashed requests are dropped; a response landing
    // in the redirect cycle is discarded as well.
    assign rsp_drop = ic_rsp_valid && (drop_cnt_q != '0);
    assign enqueue  = ic_rsp_valid && (drop_cnt_q == '0) && !redirect;
    assign dequeue  = instr_valid && instr_ready;

    assign enq_entry = '{instr: ic_rsp_data, pc: rsp_pc_q, fault: ic_rsp_fault};

    // Next-state for the PCs and the credit/drop counters.
    always_comb begin
        outstanding_d = outstanding_q;
        drop_cnt_d    = drop_cnt_q;
        req_pc_d      = req_pc_q;
        rsp_pc_d      = rsp_pc_q;

        case ({req_fire, ic_rsp_valid})
            2'b10:   outstanding_d = outstanding_q + CNT_W'(1);
            2'b01:   outstanding_d = outstanding_q - CNT_W'(1);
            default: outstanding_d = outstanding_q;
        endcase

        if (redirect) begin
            // Everything still in flight after this cycle's accounting is stale.
            drop_cnt_d = outstanding_d;
            req_pc_d   = redirect_target;
            rsp_pc_d   = redirect_target;
        end else begin
            if (rsp_drop) drop_cnt_d = drop_cnt_q - CNT_W'(1);
            if (req_fire) req_pc_d   = req_pc_q + PC_INC;
            if (enqueue)  rsp_pc_d   = rsp_pc_q + PC_INC;
        end
    end

    // PC and counter registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            req_pc_q      <= BOOT_ADDR;
            rsp_pc_q      <= BOOT_ADDR;
            outstanding_q <= '0;
            drop_cnt_q    <= '0;
        end else begin
            req_pc_q      <= req_pc_d;
            rsp_pc_q      <= rsp_pc_d;
            outstanding_q <= outstanding_d;
            drop_cnt_q    <= drop_cnt_d;
        end
    end

    // Fetch FSM: a faulting word halts fetch until the next redirect.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= FETCH;
        end else if (redirect) begin
            state_q <= FETCH;
        end else if (enqueue && ic_rsp_fault) begin
            state_q <= HALTED;
        end
    end

    cpu_fetch_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (entry_t)
    ) u_fifo (
        .clock       (clock),
        .reset       (reset),
        .push_i      (enqueue),
        .push_data_i (enq_entry),
        .pop_i       (dequeue),
        .flush_i     (redirect),
        .head_o      (head),
        .count_o     (fifo_count),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty)
    );

    assign instr_valid = !fifo_empty;
    assign instr       = head.instr;
    assign instr_pc    = head.pc;
    assign instr_fault = head.fault;

endmodule

// File: tb/tb_cpu_fetch_prefetch.sv
// Directed bench for cpu_fetch_prefetch with a 1-cycle icache model and an
// in-order scoreboard of accepted requests.
module tb_cpu_fetch_prefetch;

    localparam logic [31:0] BOOT = 32'h0000_1000;
    localparam logic [31:0] EXC  = 32'h0000_2000;

    logic        clock = 1'b0;
    logic        reset;
    logic        redirect_exception;
    logic        redirect_jump;
    logic [31:0] jump_pc;
    logic        ic_req_valid;
    logic        ic_req_ready;
    logic [31:0] ic_req_addr;
    logic        ic_rsp_valid;
    logic [31:0] ic_rsp_data;
    logic        ic_rsp_fault;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_fault;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        fault;
    } exp_t;

    exp_t        exp_q  [$];   // accepted since the last redirect, not yet consumed
    exp_t        pend_q [$];   // icache responses not yet returned
    logic [31:0] exp_req_pc;
    logic        rsp_hold;
    logic        fault_arm;
    logic [31:0] fault_addr;
    logic        saw_wrap;
    int          n_pass;
    int          n_checks;
    int          n_delivered;
    int          n_faults;

    cpu_fetch_prefetch dut (
        .clock              (clock),
        .reset              (reset),
        .redirect_exception (redirect_exception),
        .redirect_jump      (redirect_jump),
        .jump_pc            (jump_pc),
        .ic_req_valid       (ic_req_valid),
        .ic_req_ready       (ic_req_ready),
        .ic_req_addr        (ic_req_addr),
        .ic_rsp_valid       (ic_rsp_valid),
        .ic_rsp_data        (ic_rsp_data),
        .ic_rsp_fault       (ic_rsp_fault),
        .instr_valid        (instr_valid),
        .instr_ready        (instr_ready),
        .instr              (instr),
        .instr_pc           (instr_pc),
        .instr_fault        (instr_fault)
    );

    always #5 clock = ~clock;

    initial begin
        #500000;
        $display("FAIL watchdog: run did not reach the summary");
        $fatal(1, "watchdog expired");
    end

    function automatic logic [31:0] data_of(input logic [31:0] a);
        return a ^ 32'hA5C3_0F96;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // One clock cycle, entered just after a falling edge with inputs already set.
    task automatic step();
        exp_t r;
        exp_t e;
        if (!rsp_hold && pend_q.size() != 0) begin
            r = pend_q.pop_front();
            ic_rsp_valid = 1'b1;
            ic_rsp_data  = r.instr;
            ic_rsp_fault = r.fault;
        end else begin
            ic_rsp_valid = 1'b0;
            ic_rsp_data  = '0;
            ic_rsp_fault = 1'b0;
        end
        #1;
        if (instr_valid && instr_ready) begin
            check("sb_has_entry", exp_q.size() != 0, 1'b1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("instr_pc", instr_pc, e.pc);
                check("instr", instr, e.instr);
                check("instr_fault", instr_fault, e.fault);
            end
            n_delivered++;
            if (instr_fault) n_faults++;
        end
        if (redirect_exception || redirect_jump) begin
            check("req_blocked_on_redirect", ic_req_valid, 1'b0);
            exp_q.delete();
            exp_req_pc = redirect_exception ? EXC : (jump_pc & ~32'h3);
        end else if (ic_req_valid && ic_req_ready) begin
            check("req_addr", ic_req_addr, exp_req_pc);
            if (ic_req_addr == 32'h0) saw_wrap = 1'b1;
            r = '{instr: data_of(exp_req_pc), pc: exp_req_pc,
                  fault: fault_arm && (exp_req_pc == fault_addr)};
            pend_q.push_back(r);
            exp_q.push_back(r);
            exp_req_pc = exp_req_pc + 32'd4;
        end
        @(negedge clock);
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_valid(input string tag, input int budget);
        int i;
        i = 0;
        while (!instr_valid && i < budget) begin
            step();
            i++;
        end
        check(tag, instr_valid, 1'b1);
    endtask

    task automatic redirect_to(input logic exc, input logic jmp, input logic [31:0] target);
        redirect_exception = exc;
        redirect_jump      = jmp;
        jump_pc            = target;
        step();
        redirect_exception = 1'b0;
        redirect_jump      = 1'b0;
    endtask

    initial begin
        reset = 1'b0;
        redirect_exception = 1'b0;
        redirect_jump = 1'b0;
        jump_pc = '0;
        ic_req_ready = 1'b1;
        ic_rsp_valid = 1'b0;
        ic_rsp_data = '0;
        ic_rsp_fault = 1'b0;
        instr_ready = 1'b1;
        exp_req_pc = BOOT;
        rsp_hold = 1'b0;
        fault_arm = 1'b0;
        fault_addr = '0;
        saw_wrap = 1'b0;
        n_pass = 0;
        n_checks = 0;
        n_delivered = 0;
        n_faults = 0;

        // Reset state
        #3;
        check("rst_req_valid", ic_req_valid, 1'b0);
        check("rst_instr_valid", instr_valid, 1'b0);
        check("rst_instr", instr, 32'h0);
        check("rst_instr_pc", instr_pc, 32'h0);
        check("rst_instr_fault", instr_fault, 1'b0);

        // Release: first request at BOOT, then one instruction per cycle
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("boot_req_valid", ic_req_valid, 1'b1);
        check("boot_req_addr", ic_req_addr, BOOT);
        run(12);
        check("stream_rate", n_delivered, 10);

        // Icache stall: request stays valid and its address stays put
        ic_req_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check("stall_req_valid", ic_req_valid, 1'b1);
            check("stall_req_addr", ic_req_addr, exp_req_pc);
        end
        ic_req_ready = 1'b1;
        run(4);

        // Decode stall: queue fills to DEPTH, requests stop, nothing lost
        instr_ready = 1'b0;
        run(10);
        check("bp_req_valid", ic_req_valid, 1'b0);
        check("bp_queued", exp_q.size(), 4);
        check("bp_instr_valid", instr_valid, 1'b1);
        instr_ready = 1'b1;
        run(8);

        // Jump with two responses in flight: both dropped
        rsp_hold = 1'b1;
        run(4);
        check("max_out_inflight", pend_q.size(), 2);
        check("max_out_block", ic_req_valid, 1'b0);
        redirect_to(1'b0, 1'b1, 32'h0000_4000);
        check("jump_flush", instr_valid, 1'b0);
        rsp_hold = 1'b0;
        instr_ready = 1'b0;
        wait_valid("jump_wait", 20);
        check("jump_first_pc", instr_pc, 32'h0000_4000);
        instr_ready = 1'b1;
        run(6);

        // Exception and jump together: exception wins
        redirect_to(1'b1, 1'b1, 32'h0000_5000);
        instr_ready = 1'b0;
        wait_valid("exc_wait", 20);
        check("exc_first_pc", instr_pc, EXC);
        check("exc_first_instr", instr, data_of(EXC));
        instr_ready = 1'b1;
        run(4);

        // Fault at 0x1008: delivered with the flag, fetch halts until a redirect
        fault_arm = 1'b1;
        fault_addr = 32'h0000_1008;
        n_faults = 0;
        redirect_to(1'b0, 1'b1, 32'h0000_1002);
        run(14);
        check("fault_delivered", n_faults, 1);
        check("fault_drained", exp_q.size(), 0);
        for (int i = 0; i < 5; i++) begin
            step();
            check("halt_no_req", ic_req_valid, 1'b0);
        end
        fault_arm = 1'b0;
        redirect_to(1'b0, 1'b1, 32'h0000_3000);
        #1;
        check("resume_req_valid", ic_req_valid, 1'b1);
        check("resume_req_addr", ic_req_addr, 32'h0000_3000);
        run(6);

        // Address wrap past the top of the space
        redirect_to(1'b0, 1'b1, 32'hFFFF_FFF8);
        run(8);
        check("wrap_seen", saw_wrap, 1'b1);

        // Reset mid-stream
        reset = 1'b0;
        ic_rsp_valid = 1'b0;
        ic_rsp_data = '0;
        ic_rsp_fault = 1'b0;
        #1;
        check("mid_rst_req_valid", ic_req_valid, 1'b0);
        check("mid_rst_instr_valid", instr_valid, 1'b0);
        check("mid_rst_instr", instr, 32'h0);
        check("mid_rst_instr_pc", instr_pc, 32'h0);
        check("mid_rst_instr_fault", instr_fault, 1'b0);
        pend_q.delete();
        exp_q.delete();
        exp_req_pc = BOOT;
        @(negedge clock);
        reset = 1'b1;
        #1;
        check("post_rst_req_valid", ic_req_valid, 1'b1);
        check("post_rst_req_addr", ic_req_addr, BOOT);
        run(8);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
